fir_coef_bank: RTL and testbench

// - Parametrised, run-time loadable FIR coefficient store; successor to the fixed fp16 coefficient ROMs.
// - Two banks, ping-pong: the filter datapath reads the active bank while a host stream loads the shadow bank.
// - A swap request makes the shadow bank active at a clean cycle boundary.
// - Sits between the FPU config loader and the FIR MAC datapath; coefficient words are opaque (fp16 by default).

---
 rtl/fir_coef_bank.sv | 161 ++++++++++++++++
 tb/tb_fir_coef_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_bank.sv
//==============================================================================
// Module      : fir_coef_bank
// Description : Ping-pong FIR coefficient store. The filter reads the active
//               bank while a host stream fills the shadow bank; a swap makes
//               the shadow bank active at a clean cycle boundary.
//               Optional feature macro: COEF_SYM_EN (symmetric half-length
//               banks with folded read addressing).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fir_coef_bank #(
    parameter  int DW   = 16,
    parameter  int TAPS = 64,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          ld_done,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          act_bank,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

`ifdef COEF_SYM_EN
    localparam int NLD = TAPS / 2;
`else
    localparam int NLD = TAPS;
`endif
    localparam int CW = (NLD > 1) ? $clog2(NLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_loaded;
    logic            r_pend;
    logic [DW-1:0]   r_mem [2][NLD];

    logic            w_wr_en;
    logic            w_last;
    logic            w_oor;
    logic [CW-1:0]   w_idx;
    logic [DW-1:0]   w_rd_word;

    assign w_wr_en = (r_state == ST_LOAD) && ld_valid && ld_ready && !ld_start;
    assign w_last  = (r_cnt == CW'(NLD - 1));

    // Loader FSM; the shadow bank is always the one not currently active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_loaded <= 2'b00;
            r_pend   <= 1'b0;
            act_bank <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            ld_done  <= 1'b0;
            swap_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ld_start) begin
                        r_state            <= ST_LOAD;
                        r_cnt              <= '0;
                        ld_ready           <= 1'b1;
                        r_loaded[~act_bank] <= 1'b0;
                        r_pend             <= swap_req;
                    end else if (swap_req && r_loaded[~act_bank]) begin
                        act_bank <= ~act_bank;
                        swap_ack <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (swap_req) begin
                        r_pend <= 1'b1;
                    end
                    if (ld_start) begin
                        r_cnt <= '0;
                    end else if (w_wr_en) begin
                        if (w_last) begin
                            r_loaded[~act_bank] <= 1'b1;
                            ld_done            <= 1'b1;
                            ld_ready           <= 1'b0;
                            r_state            <= ST_FULL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (ld_start) begin
                        r_state            <= ST_LOAD;
                        r_cnt              <= '0;
                        ld_ready           <= 1'b1;
                        r_loaded[~act_bank] <= 1'b0;
                        r_pend             <= r_pend | swap_req;
                    end else if (swap_req || r_pend) begin
                        act_bank <= ~act_bank;
                        swap_ack <= 1'b1;
                        r_pend   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[~act_bank][r_cnt] <= ld_data;
        end
    end

    always_comb begin
        w_idx = CW'(rd_addr);
`ifdef COEF_SYM_EN
        if (rd_addr >= AW'(TAPS / 2)) begin
            w_idx = CW'(AW'(TAPS - 1) - rd_addr);
        end
`endif
    end

    assign w_oor     = ({1'b0, rd_addr} >= (AW + 1)'(TAPS));
    assign w_rd_word = (w_oor || !r_loaded[act_bank]) ? '0 : r_mem[act_bank][w_idx];

    // Bank is sampled at issue, so a read racing a swap sees the old bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= w_rd_word;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_bank.sv
//==============================================================================
// Module      : tb_fir_coef_bank
// Description : Directed self-checking bench for fir_coef_bank (COEF_SYM_EN
//               aware).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fir_coef_bank;

    localparam int DW   = 16;
    localparam int TAPS = 64;
    localparam int AW   = $clog2(TAPS);
`ifdef COEF_SYM_EN
    localparam int NLD = TAPS / 2;
`else
    localparam int NLD = TAPS;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_done;
    logic          swap_req;
    logic          swap_ack;
    logic          act_bank;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int total = 0;
    int bad   = 0;

    fir_coef_bank #(.DW(DW), .TAPS(TAPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .swap_req (swap_req),
        .swap_ack (swap_ack),
        .act_bank (act_bank),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        swap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_act_bank", 32'(act_bank), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_ld_done",  32'(ld_done),  32'd0);
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);

        // Read of an unloaded bank returns zero.
        rd_en = 1'b1; rd_addr = AW'(5);
        step();
        chk("rd_empty_valid", 32'(rd_valid), 32'd1);
        chk("rd_empty_data",  32'(rd_data),  32'd0);
        rd_en = 1'b0;
        step();
        chk("rd_idle_valid", 32'(rd_valid), 32'd0);

        // Load bank 1 with 0x1000+i, no stalls.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("ld_ready_up", 32'(ld_ready), 32'd1);
        for (int i = 0; i < NLD; i++) begin
            ld_valid = 1'b1; ld_data = DW'(16'h1000 + i);
            step();
            chk("ld_done_a", 32'(ld_done), (i == NLD - 1) ? 32'd1 : 32'd0);
        end
        ld_valid = 1'b0;
        chk("ld_ready_down", 32'(ld_ready), 32'd0);
        step();
        chk("ld_done_pulse", 32'(ld_done), 32'd0);

        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("swap1_ack", 32'(swap_ack), 32'd1);
        chk("swap1_bank", 32'(act_bank), 32'd1);
        rd_en = 1'b1; rd_addr = AW'(3);
        step();
        chk("swap1_ack_pulse", 32'(swap_ack), 32'd0);
        chk("rd_b1_a3", 32'(rd_data), 32'h1003);
        rd_addr = AW'(60);
        step();
`ifdef COEF_SYM_EN
        chk("rd_b1_a60", 32'(rd_data), 32'h1003);
`else
        chk("rd_b1_a60", 32'(rd_data), 32'h103C);
`endif
        rd_addr = AW'(32);
        step();
`ifdef COEF_SYM_EN
        chk("rd_b1_a32", 32'(rd_data), 32'h101F);
`else
        chk("rd_b1_a32", 32'(rd_data), 32'h1020);
`endif
        rd_addr = AW'(63);
        step();
`ifdef COEF_SYM_EN
        chk("rd_b1_a63", 32'(rd_data), 32'h1000);
`else
        chk("rd_b1_a63", 32'(rd_data), 32'h103F);
`endif
        rd_en = 1'b0;
        step();
        chk("rd_hold_data",  32'(rd_data),  chk_hold_exp());
        chk("rd_hold_valid", 32'(rd_valid), 32'd0);

        // Load bank 0 with 0x2000+i, swap requested mid-load at i=10.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < NLD; i++) begin
            ld_valid = 1'b1; ld_data = DW'(16'h2000 + i);
            swap_req = (i == 10);
            rd_en = 1'b1; rd_addr = AW'(3);
            step();
            chk("mid_no_ack", 32'(swap_ack), 32'd0);
            chk("mid_old_rd", 32'(rd_data), 32'h1003);
        end
        ld_valid = 1'b0; swap_req = 1'b0;
        chk("mid_ld_done", 32'(ld_done), 32'd1);
        chk("mid_bank_hold", 32'(act_bank), 32'd1);
        // This read issues in the same cycle the pending swap executes.
        rd_addr = AW'(3);
        step();
        chk("mid_ack", 32'(swap_ack), 32'd1);
        chk("mid_bank", 32'(act_bank), 32'd0);
        chk("race_old_rd", 32'(rd_data), 32'h1003);
        step();
        chk("race_new_rd", 32'(rd_data), 32'h2003);
        rd_en = 1'b0;

        // Restart mid-load: first words overwritten by the second pass.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = DW'(16'h4000 + i);
            step();
        end
        ld_valid = 1'b0; ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < NLD; i++) begin
            ld_valid = 1'b1; ld_data = DW'(16'h5000 + i);
            step();
        end
        ld_valid = 1'b0;
        chk("rst_ld_done2", 32'(ld_done), 32'd1);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("swap3_bank", 32'(act_bank), 32'd1);
        rd_en = 1'b1; rd_addr = AW'(3);
        step();
        chk("restart_rd", 32'(rd_data), 32'h5003);
        rd_en = 1'b0;

        // Reset at i=7 of a load discards everything; swap is then refused.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1; ld_data = DW'(16'h3000 + i);
            step();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", 32'(ld_ready), 32'd0);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("midrst_no_ack", 32'(swap_ack), 32'd0);
        chk("midrst_bank", 32'(act_bank), 32'd0);
        rd_en = 1'b1; rd_addr = AW'(3);
        step();
        chk("midrst_no_ack2", 32'(swap_ack), 32'd0);
        chk("midrst_rd", 32'(rd_data), 32'd0);
        rd_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [31:0] chk_hold_exp();
`ifdef COEF_SYM_EN
        return 32'h1000;
`else
        return 32'h103F;
`endif
    endfunction

endmodule

`default_nettype wire
